// File: rtl/cache_dm_wt_if.sv
// cache_dm_wt_if: processor request, RAM and debug-counter signals of the direct-mapped cache
interface cache_dm_wt_if #(
  parameter int d_width = 8,
  parameter int a_width = 8,
  parameter int cnt_width = 8
);
  logic ce, rw, flush, odv, busy, ram_ce, ram_rw;
  logic [a_width-1:0] addr, ram_addr;
  logic [d_width-1:0] din, dout, ram_wdata, ram_rdata;
  logic [cnt_width-1:0] hit_count, miss_count;
  modport master (
    output ce, rw, addr, din, flush, ram_rdata,
    input dout, odv, busy, ram_addr, ram_wdata, ram_ce, ram_rw, hit_count, miss_count
  );
  modport slave (
    input ce, rw, addr, din, flush, ram_rdata,
    output dout, odv, busy, ram_addr, ram_wdata, ram_ce, ram_rw, hit_count, miss_count
  );
endinterface

// File: rtl/cache_dm_wt.sv
// cache_dm_wt: direct-mapped write-through no-write-allocate cache, one word per line
module cache_dm_wt #(
  parameter int d_width = 8,
  parameter int a_width = 8,
  parameter int index_width = 4,
  parameter int mem_wait = 2,
  parameter int cnt_width = 8
) (
  input logic clk,
  input logic clr,
  cache_dm_wt_if.slave bus
);
  localparam int lines = 1 << index_width;
  localparam int tag_width = a_width - index_width;
  localparam int wait_width = $clog2(mem_wait) + 1;
  localparam logic [wait_width-1:0] last_wait = wait_width'(mem_wait - 1);
  typedef enum logic [2:0] {IDLE, HIT, FILL, WRITE, DONE} state_t;
  state_t state_q;
  logic [lines-1:0] valid_q;
  logic [tag_width-1:0] tag_q [lines];
  logic [d_width-1:0] data_q [lines];
  logic [wait_width-1:0] wait_q;
  logic [d_width-1:0] dout_q, ram_wdata_q;
  logic [a_width-1:0] ram_addr_q;
  logic odv_q, busy_q, ram_ce_q, ram_rw_q, req_hit;
  logic [cnt_width-1:0] hit_q, miss_q, hit_d, miss_d;
  logic [index_width-1:0] req_idx, cur_idx;
  logic [tag_width-1:0] req_tag, cur_tag;
  assign req_idx = bus.addr[index_width-1:0];
  assign req_tag = bus.addr[a_width-1:index_width];
  // ram_addr_q doubles as the latched request address for every non-idle state
  assign cur_idx = ram_addr_q[index_width-1:0];
  assign cur_tag = ram_addr_q[a_width-1:index_width];
  assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign hit_d = &hit_q ? hit_q : hit_q + 1'b1;
  assign miss_d = &miss_q ? miss_q : miss_q + 1'b1;
  assign bus.dout = dout_q;
  assign bus.odv = odv_q;
  assign bus.busy = busy_q;
  assign bus.ram_ce = ram_ce_q;
  assign bus.ram_rw = ram_rw_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.hit_count = hit_q;
  assign bus.miss_count = miss_q;
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      valid_q <= '0;
      wait_q <= '0;
      dout_q <= '0;
      odv_q <= 1'b0;
      busy_q <= 1'b0;
      ram_ce_q <= 1'b0;
      ram_rw_q <= 1'b1;
      ram_addr_q <= '0;
      ram_wdata_q <= '0;
      hit_q <= '0;
      miss_q <= '0;
    end else begin
      odv_q <= 1'b0;
      case (state_q)
        IDLE:
          if (bus.flush) valid_q <= '0;
          else if (bus.ce) begin
            ram_addr_q <= bus.addr;
            ram_wdata_q <= bus.din;
            busy_q <= 1'b1;
            wait_q <= '0;
            if (!bus.rw) begin
              state_q <= WRITE;
              ram_ce_q <= 1'b1;
              ram_rw_q <= 1'b0;
              if (req_hit) data_q[req_idx] <= bus.din;
            end else if (req_hit) state_q <= HIT;
            else begin
              state_q <= FILL;
              ram_ce_q <= 1'b1;
              ram_rw_q <= 1'b1;
            end
          end
        HIT: begin
          dout_q <= data_q[cur_idx];
          odv_q <= 1'b1;
          hit_q <= hit_d;
          busy_q <= 1'b0;
          state_q <= IDLE;
        end
        FILL:
          if (wait_q == last_wait) begin
            data_q[cur_idx] <= bus.ram_rdata;
            tag_q[cur_idx] <= cur_tag;
            valid_q[cur_idx] <= 1'b1;
            miss_q <= miss_d;
            ram_ce_q <= 1'b0;
            state_q <= DONE;
          end else wait_q <= wait_q + 1'b1;
        WRITE:
          if (wait_q == last_wait) begin
            ram_ce_q <= 1'b0;
            ram_rw_q <= 1'b1;
            busy_q <= 1'b0;
            state_q <= IDLE;
          end else wait_q <= wait_q + 1'b1;
        DONE: begin
          dout_q <= data_q[cur_idx];
          odv_q <= 1'b1;
          busy_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_dm_wt.sv
// tb_cache_dm_wt: random and directed requests against a word-level cache model with a read scoreboard
module tb_cache_dm_wt;
  localparam int mem_wait = 2;
  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;
  cache_dm_wt_if #(.d_width(8), .a_width(8), .cnt_width(8)) bus ();
  cache_dm_wt_if #(.d_width(8), .a_width(8), .cnt_width(2)) bus2 ();
  cache_dm_wt #(.mem_wait(mem_wait)) dut (.clk(clk), .clr(clr), .bus(bus));
  cache_dm_wt #(.mem_wait(mem_wait), .cnt_width(2)) dut2 (.clk(clk), .clr(clr), .bus(bus2));
  logic [7:0] ram [256];
  assign bus.ram_rdata = ram[bus.ram_addr];
  assign bus2.ram_rdata = ram[bus2.ram_addr];
  assign bus2.ce = bus.ce;
  assign bus2.rw = bus.rw;
  assign bus2.addr = bus.addr;
  assign bus2.din = bus.din;
  assign bus2.flush = bus.flush;
  function automatic logic [7:0] init_val(int i);
    return i == 5 ? 8'h5A : i == 8'h15 ? 8'h77 : 8'(i * 37 + 11);
  endfunction
  always @(posedge clk)
    if (clr) for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
    else if (bus.ram_ce && !bus.ram_rw) ram[bus.ram_addr] <= bus.ram_wdata;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {logic [7:0] data; int due;} exp_t;
  exp_t sb[$];
  int checks = 0, passes = 0;
  logic [7:0] ref_mem [256];
  bit ref_valid [16];
  logic [3:0] ref_tag [16];
  int exp_hits, exp_miss;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic model_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
    exp_hits = 0;
    exp_miss = 0;
  endtask
  task automatic check_counts();
    chk("hit_count", bus.hit_count, exp_hits > 255 ? 255 : exp_hits);
    chk("miss_count", bus.miss_count, exp_miss > 255 ? 255 : exp_miss);
    chk("hit_count_sat2", bus2.hit_count, exp_hits > 3 ? 3 : exp_hits);
  endtask
  // Called at a negedge with the cache idle; returns at a negedge with it idle again.
  task automatic req(input bit r, input logic [7:0] a, input logic [7:0] d);
    bit hit;
    int n, ce_cyc, exp_ce;
    hit = ref_valid[a[3:0]] && ref_tag[a[3:0]] == a[7:4];
    bus.ce = 1'b1; bus.rw = r; bus.addr = a; bus.din = d;
    if (r) begin
      sb.push_back(exp_t'{ref_mem[a], cyc + (hit ? 2 : mem_wait + 2)});
      if (hit) exp_hits++;
      else begin
        exp_miss++;
        ref_valid[a[3:0]] = 1'b1;
        ref_tag[a[3:0]] = a[7:4];
      end
    end else ref_mem[a] = d;
    exp_ce = (r && hit) ? 0 : mem_wait;
    @(negedge clk);
    bus.ce = 1'b0;
    chk("busy_after_ce", bus.busy, 1);
    ce_cyc = 0;
    n = 0;
    while (bus.busy && n < 50) begin
      if (bus.ram_ce) ce_cyc++;
      n++;
      @(negedge clk);
    end
    chk("busy_released", bus.busy, 0);
    chk("ram_ce_cycles", ce_cyc, exp_ce);
    check_counts();
  endtask
  task automatic do_flush(input bit with_ce, input logic [7:0] a);
    bus.flush = 1'b1; bus.ce = with_ce; bus.rw = 1'b1; bus.addr = a;
    @(negedge clk);
    bus.flush = 1'b0; bus.ce = 1'b0;
    chk("flush_busy", bus.busy, 0);
    chk("flush_ram_ce", bus.ram_ce, 0);
    for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
  endtask
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (bus.odv === 1'b1) begin
      checks++;
      if (sb.size() == 0) $display("FAIL odv_unexpected: got dout %0h at cycle %0d expected no pulse", bus.dout, cyc);
      else begin
        e = sb.pop_front();
        if (bus.dout === e.data && cyc == e.due && bus2.odv === 1'b1 && bus2.dout === e.data) passes++;
        else $display("FAIL read_data: got %0h/%0h at cycle %0d expected %0h at cycle %0d",
                      bus.dout, bus2.dout, cyc, e.data, e.due);
      end
    end
  end
  initial begin
    bus.ce = 1'b0; bus.rw = 1'b1; bus.addr = '0; bus.din = '0; bus.flush = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    clr = 1'b0;
    chk("rst_dout", bus.dout, 0);
    chk("rst_odv", bus.odv, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ram_ce", bus.ram_ce, 0);
    chk("rst_ram_rw", bus.ram_rw, 1);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_wdata", bus.ram_wdata, 0);
    check_counts();
    req(1, 8'h05, 8'h00);
    req(1, 8'h05, 8'h00);
    req(0, 8'h05, 8'hC3);
    chk("ram_written", ram[5], 8'hC3);
    req(1, 8'h05, 8'h00);
    req(1, 8'h15, 8'h00);
    req(1, 8'h05, 8'h00);
    do_flush(1'b1, 8'h05);
    req(1, 8'h05, 8'h00);
    bus.ce = 1'b1; bus.rw = 1'b1; bus.addr = 8'h25;
    @(negedge clk);
    bus.ce = 1'b0;
    chk("fill_ram_ce", bus.ram_ce, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_ram_ce", bus.ram_ce, 0);
    chk("clr_busy", bus.busy, 0);
    model_reset();
    check_counts();
    repeat (6) @(negedge clk);
    req(1, 8'h05, 8'h00);
    for (int k = 0; k < 200; k++) begin
      int r;
      logic [7:0] a;
      r = $urandom_range(0, 9);
      a = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 7))};
      if (r == 0) do_flush(1'($urandom_range(0, 1)), a);
      else if (r < 4) req(0, a, 8'($urandom));
      else req(1, a, 8'h00);
    end
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/cache_dm_wt.md
Name: cache_dm_wt

Overview:
- Parametrised direct-mapped, write-through, no-write-allocate data cache placed between the processor datapath and the single-port data RAM.
- Successor to the fixed 8-bit cache; generalised in data width, address width, line count and RAM wait states.
- Adds a flush command, a busy handshake and saturating hit/miss counters for bench and debug use.
- One word per line.

Parameters:
- d_width, 8, data bus width in bits.
- a_width, 8, address width in bits (word addressed).
- index_width, 4, log2 of line count; must be less than a_width.
- mem_wait, 2, RAM access cycles with ram_ce held (minimum 1).
- cnt_width, 8, width of the hit and miss counters.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clr  input  1  synchronous active-high reset.
- ce  input  1  request strobe from the processor; sampled only in IDLE.
- rw  input  1  request type: 1 = read, 0 = write.
- addr  input  a_width  request word address.
- din  input  d_width  write data.
- flush  input  1  invalidate all lines; sampled only in IDLE.
- dout  output  d_width  read data; held until the next read completes.
- odv  output  1  one-cycle pulse; dout is valid for a read.
- busy  output  1  high while a request or flush is being serviced.
- ram_addr  output  a_width  RAM address.
- ram_wdata  output  d_width  RAM write data.
- ram_rdata  input  d_width  RAM read data, valid in the last wait cycle.
- ram_ce  output  1  RAM chip enable.
- ram_rw  output  1  RAM direction: 1 = read, 0 = write.
- hit_count  output  cnt_width  saturating count of read hits.
- miss_count  output  cnt_width  saturating count of read misses.

Behaviour:
Reset:
- clr high at an edge: state goes to IDLE.
- All valid bits cleared.
- dout, odv, busy, ram_ce, ram_addr and ram_wdata go to 0; ram_rw goes to 1.
- Both counters go to 0.
- clr overrides any in-flight access; ram_ce is low after that edge and no odv pulse follows.

Address split:
- index = addr[index_width-1:0].
- tag = addr[a_width-1:index_width].
- Line storage per index: a valid bit, the tag and the data.

States: IDLE, HIT, FILL, WRITE, DONE.
- IDLE: busy = 0.
  - flush high: all valid bits clear at that edge; any ce in the same cycle is dropped; state stays IDLE.
  - Otherwise ce high: latch addr, rw and din, set busy = 1, then branch on request type.
  - Read that hits (valid and tag match): go to HIT.
  - Read that misses: go to FILL.
  - Write: go to WRITE.
  - ce while busy = 1 is ignored, never queued.
- HIT: dout = line data, odv = 1, hit_count += 1 (saturating at all ones), go to IDLE.
  - Read-hit latency: odv asserts on the 2nd edge after the ce edge.
- FILL:
  - Outputs: ram_ce = 1, ram_rw = 1, ram_addr = latched address.
  - Held for exactly mem_wait cycles, timed by a wait counter.
  - Last cycle: capture ram_rdata into the line, set tag and valid, then go to DONE.
  - miss_count += 1 (saturating).
- WRITE:
  - Outputs: ram_ce = 1, ram_rw = 0, ram_addr and ram_wdata = latched values.
  - Held for mem_wait cycles.
  - Hit: line data is updated with din on entry.
  - Miss: cache contents are untouched.
  - Then go to IDLE; no odv pulse for writes.
- DONE: dout = filled data, odv = 1, go to IDLE.
  - Read-miss latency: odv asserts mem_wait+2 edges after the ce edge.

Other rules:
- ram_ce is 0 in IDLE, HIT and DONE.
- busy is 0 in IDLE and 1 in every other state.
- A conflicting read (same index, different tag) replaces the line.
- Writes never change either counter.

Test Plan:
- Defaults; RAM[0x05] = 0x5A; after clr, read 0x05 -> FILL with ram_ce high for 2 cycles; odv at edge 4 with dout = 0x5A; miss_count = 1; hit_count = 0.
- Read 0x05 again -> odv at edge 2 with dout = 0x5A; ram_ce stays low; hit_count = 1.
- Write 0xC3 to 0x05, then read 0x05 -> RAM[0x05] = 0xC3 after 2 write cycles; read hits and returns 0xC3.
- Read 0x15 (same index 5, tag 1; RAM = 0x77), then read 0x05 -> both miss; dout = 0x77 then 0xC3; miss_count increments by 2.
- flush and ce asserted in the same IDLE cycle -> request dropped, busy stays 0; next read of 0x05 misses.
- clr pulsed in the middle of FILL -> ram_ce 0 after that edge; no odv; counters 0; next read of 0x05 misses.
- cnt_width = 2, five read hits -> hit_count saturates at 3.
